fdiv_meter: RTL and testbench
=============================

FDIV_METER -- requirements
Module: fdiv_meter

Interface
REQ-001 Parameter CNT_W, default 8: width of the cycle counter and the period output.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_b  input  1  asynchronous reset, active-low.
REQ-004 clr  input  1  synchronous clear; takes priority over en.
REQ-005 en  input  1  count enable; when low, all state holds.
REQ-006 fin  input  1  divided strobe under measurement (e.g. a divider's fdclk output), synchronous to clk.
REQ-007 period  output  CNT_W  last measured cycle count between two consecutive fin rising edges.
REQ-008 period_vld  output  1  one-cycle pulse when period is updated.
REQ-009 lock  output  1  high while consecutive periods are equal.
REQ-010 ovf  output  1  high while no edge has arrived within 2^CNT_W-1 enabled cycles.

Function
REQ-011 A rising edge is detected, only on cycles with en=1, when fin_q=0 and fin=1; fin_q is the registered copy of fin, updated only when en=1.
REQ-012 The FSM SHALL be one-hot with five states: IDLE, FIRST, MEAS, LOCK, OVF.
REQ-013 IDLE: on edge -> cnt<=1, go to FIRST; otherwise cnt holds at 0.
REQ-014 FIRST/MEAS/LOCK, cycle without edge: cnt<=cnt+1.
REQ-015 FIRST/MEAS/LOCK, edge cycle: period<=cnt, period_vld<=1 next cycle, cnt<=1.
REQ-016 FIRST on edge -> MEAS.
REQ-017 MEAS on edge: go to LOCK if cnt equals the current period register, else stay in MEAS.
REQ-018 LOCK on edge: stay in LOCK if cnt equals period, else go to MEAS.
REQ-019 In FIRST/MEAS/LOCK with cnt=2^CNT_W-1 and no edge: go to OVF; cnt holds; period holds; no period_vld.
REQ-020 Edge coincident with cnt=2^CNT_W-1 is a valid measurement (period=255 for CNT_W=8); no overflow is flagged.
REQ-021 OVF on edge: cnt<=1, go to FIRST, no period_vld.
REQ-022 Output decode: lock = state LOCK; ovf = state OVF. Both are registered with no combinational path from inputs.
REQ-023 period_vld SHALL be 0 on every cycle not immediately following an enabled edge in FIRST/MEAS/LOCK.
REQ-024 en=0: state, cnt, period, and fin_q hold; period_vld=0 on the next cycle.
REQ-025 Only enabled cycles are counted, so period is expressed in en-qualified clk cycles.
REQ-026 clr=1: state<=IDLE, cnt<=0, period<=0, period_vld<=0, fin_q<=fin. This applies regardless of en.

Reset
REQ-027 rst_b=0: state=IDLE, cnt=0, period=0, period_vld=0, lock=0, ovf=0, fin_q=1.
REQ-028 fin_q resets to 1 so that a fin held high at reset release produces no spurious edge.
REQ-029 Reset asserted mid-measurement discards the measurement in progress; the first edge after release only arms FIRST.

Structure
REQ-030 Shared package fdiv_pkg SHALL hold the one-hot state index constants (IDLE..OVF) and the default CNT_W.
REQ-031 Edge detection (fin_q register plus the rise term, gated by en) SHALL be the sub-module rise_det.
REQ-032 The FSM next-state logic SHALL be written as per-bit one-hot equations.

Verification
REQ-033 Divide-by-4 strobe (edge every 4 cycles, en=1) -> period_vld with period=4 one cycle after edge 2; lock=1 one cycle after edge 3 and stays high.
REQ-034 Locked at 4, then the edge spacing changes to 6 -> period=6 with vld, lock=0 after the first 6-cycle edge; lock=1 again after the second 6-cycle edge.
REQ-035 en low for 3 cycles inside a 7-clk edge spacing -> period=4, lock undisturbed.
REQ-036 fin held 0 for 300 cycles after FIRST -> ovf=1 on the cycle after cnt reaches 255, no vld; the next edge -> ovf=0, state FIRST.
REQ-037 clr pulse mid-period while locked -> lock=0, period=0 next cycle; two further edges -> period_vld with the correct period.
REQ-038 rst_b low for 1 cycle while fin=1 and locked -> all outputs 0; fin staying high after release -> no period_vld.

Source files
------------

// File: rtl/fdiv_meter_pkg.sv
// Shared constants for the divided-strobe period meter.
package fdiv_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  // One-hot state bit indices
  localparam int unsigned NumSt = 5;
  localparam int unsigned IDLE  = 0;
  localparam int unsigned FIRST = 1;
  localparam int unsigned MEAS  = 2;
  localparam int unsigned LOCK  = 3;
  localparam int unsigned OVF   = 4;

  typedef enum logic [NumSt-1:0] {
    StIdle  = 5'b00001,
    StFirst = 5'b00010,
    StMeas  = 5'b00100,
    StLock  = 5'b01000,
    StOvf   = 5'b10000
  } state_e;

endpackage

// File: rtl/fdiv_meter_if.sv
// Control inputs and measurement outputs of the period meter.
interface fdiv_meter_if #(
  parameter int unsigned CNT_W = fdiv_pkg::CNT_W_DEF
) ();

  logic             clr;
  logic             en;
  logic             fin;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             lock;
  logic             ovf;

  modport master (
    output clr, en, fin,
    input  period, period_vld, lock, ovf
  );

  modport slave (
    input  clr, en, fin,
    output period, period_vld, lock, ovf
  );

endinterface

// File: rtl/fdiv_meter_rise_det.sv
// Enable-gated rising-edge detector for the measured strobe.
module rise_det (
  input  logic clk,
  input  logic rst_b,
  input  logic clr_i,
  input  logic en_i,
  input  logic fin_i,
  output logic rise_o
);

  logic fin_q, fin_d;

  // Previous-sample register only advances on enabled or clearing cycles
  always_comb begin
    fin_d = fin_q;
    if (clr_i || en_i) begin
      fin_d = fin_i;
    end
  end

  // Resets high so a strobe already high at release is not seen as an edge
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fin_q <= 1'b1;
    end else begin
      fin_q <= fin_d;
    end
  end

  assign rise_o = en_i & ~fin_q & fin_i;

endmodule

// File: rtl/fdiv_meter.sv
// Measures the spacing of strobe rising edges in enabled clock cycles and
// reports lock (equal consecutive periods) and overflow (no edge in range).
module fdiv_meter
  import fdiv_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_b,
  fdiv_meter_if.slave       bus
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [NumSt-1:0] st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             rise;
  logic             go;
  logic             in_meas;
  logic             at_max;
  logic             eq;

  rise_det u_rise_det (
    .clk    (clk),
    .rst_b  (rst_b),
    .clr_i  (bus.clr),
    .en_i   (bus.en),
    .fin_i  (bus.fin),
    .rise_o (rise)
  );

  assign go      = bus.en & ~bus.clr;
  assign in_meas = st_q[FIRST] | st_q[MEAS] | st_q[LOCK];
  assign at_max  = (cnt_q == CntMax);
  assign eq      = (cnt_q == period_q);

  // One-hot next state; disabled cycles hold, clear forces IDLE
  always_comb begin
    st_d = '0;
    st_d[IDLE]  = bus.clr | (st_q[IDLE] & ~(go & rise));
    st_d[FIRST] = ~bus.clr & ((~bus.en & st_q[FIRST]) |
                  (go & (((st_q[IDLE] | st_q[OVF]) & rise) |
                         (st_q[FIRST] & ~rise & ~at_max))));
    st_d[MEAS]  = ~bus.clr & ((~bus.en & st_q[MEAS]) |
                  (go & ((rise & (st_q[FIRST] | ((st_q[MEAS] | st_q[LOCK]) & ~eq))) |
                         (st_q[MEAS] & ~rise & ~at_max))));
    st_d[LOCK]  = ~bus.clr & ((~bus.en & st_q[LOCK]) |
                  (go & ((rise & (st_q[MEAS] | st_q[LOCK]) & eq) |
                         (st_q[LOCK] & ~rise & ~at_max))));
    st_d[OVF]   = ~bus.clr & ((~bus.en & st_q[OVF]) |
                  (go & ((in_meas & ~rise & at_max) | (st_q[OVF] & ~rise))));
  end

  // Counter, period capture and valid pulse
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    vld_d    = 1'b0;
    if (bus.clr) begin
      cnt_d    = '0;
      period_d = '0;
    end else if (bus.en) begin
      if (rise) begin
        if (in_meas) begin
          period_d = cnt_q;
          vld_d    = 1'b1;
        end
        cnt_d = CntOne;
      end else if (in_meas && !at_max) begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st_q     <= StIdle;
      cnt_q    <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.period_vld = vld_q;
  assign bus.lock       = st_q[LOCK];
  assign bus.ovf        = st_q[OVF];

endmodule

// File: tb/tb_fdiv_meter.sv
// Bench for fdiv_meter: expected periods queued as edges are driven,
// popped when period_vld pulses.
module tb_fdiv_meter;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_b;

  fdiv_meter_if #(.CNT_W(W)) bus ();

  fdiv_meter #(.CNT_W(W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned sb[$];

  // Scoreboard: every valid pulse must match the oldest queued period
  always @(negedge clk) begin
    if (rst_b === 1'b1 && bus.period_vld !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_vld period_vld=%0b period=%0d expected no pulse",
                 bus.period_vld, bus.period);
      end else begin
        int unsigned exp_p;
        exp_p = sb.pop_front();
        if (bus.period !== W'(exp_p)) begin
          errors++;
          $display("FAIL sb_period got=%0d expected=%0d", bus.period, exp_p);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One-cycle high pulse on fin; returns with outputs reflecting the edge
  task automatic fin_edge();
    bus.fin = 1'b1;
    tick();
    bus.fin = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    bus.fin = 1'b1;
    bus.en = 1'b1;
    bus.clr = 1'b0;
    idle(2);
    checks++;
    if (bus.period !== 8'd0) begin errors++; $display("FAIL rst_period got=%0d expected=0", bus.period); end
    checks++;
    if (bus.period_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got=%0b expected=0", bus.period_vld); end
    checks++;
    if (bus.lock !== 1'b0) begin errors++; $display("FAIL rst_lock got=%0b expected=0", bus.lock); end
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%0b expected=0", bus.ovf); end
    rst_b = 1'b1;
    idle(3);
    bus.fin = 1'b0;
    idle(2);
  endtask

  task automatic test_div4();
    fin_edge();
    idle(3);
    sb.push_back(4);
    fin_edge();
    checks++;
    if (bus.period_vld !== 1'b1) begin errors++; $display("FAIL div4_vld got=%0b expected=1", bus.period_vld); end
    checks++;
    if (bus.lock !== 1'b0) begin errors++; $display("FAIL div4_lock_e2 got=%0b expected=0", bus.lock); end
    idle(3);
    sb.push_back(4);
    fin_edge();
    checks++;
    if (bus.lock !== 1'b1) begin errors++; $display("FAIL div4_lock_e3 got=%0b expected=1", bus.lock); end
    idle(3);
    sb.push_back(4);
    fin_edge();
    checks++;
    if (bus.lock !== 1'b1) begin errors++; $display("FAIL div4_lock_e4 got=%0b expected=1", bus.lock); end
  endtask

  task automatic test_change6();
    idle(5);
    sb.push_back(6);
    fin_edge();
    checks++;
    if (bus.lock !== 1'b0) begin errors++; $display("FAIL chg6_unlock got=%0b expected=0", bus.lock); end
    checks++;
    if (bus.period !== 8'd6) begin errors++; $display("FAIL chg6_period got=%0d expected=6", bus.period); end
    idle(5);
    sb.push_back(6);
    fin_edge();
    checks++;
    if (bus.lock !== 1'b1) begin errors++; $display("FAIL chg6_relock got=%0b expected=1", bus.lock); end
  endtask

  task automatic test_en_gap();
    idle(3);
    sb.push_back(4);
    fin_edge();
    idle(3);
    sb.push_back(4);
    fin_edge();
    idle(1);
    bus.en = 1'b0;
    idle(3);
    checks++;
    if (bus.lock !== 1'b1) begin errors++; $display("FAIL engap_lock_hold got=%0b expected=1", bus.lock); end
    bus.en = 1'b1;
    idle(2);
    sb.push_back(4);
    fin_edge();
    checks++;
    if (bus.lock !== 1'b1) begin errors++; $display("FAIL engap_lock got=%0b expected=1", bus.lock); end
    checks++;
    if (bus.period !== 8'd4) begin errors++; $display("FAIL engap_period got=%0d expected=4", bus.period); end
  endtask

  task automatic test_ovf();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    fin_edge();
    idle(254);
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got=%0b expected=0", bus.ovf); end
    idle(1);
    checks++;
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b expected=1", bus.ovf); end
    idle(45);
    checks++;
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold got=%0b expected=1", bus.ovf); end
    fin_edge();
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b expected=0", bus.ovf); end
    idle(4);
    sb.push_back(5);
    fin_edge();
    checks++;
    if (bus.lock !== 1'b0) begin errors++; $display("FAIL ovf_first_lock got=%0b expected=0", bus.lock); end
    // Edge landing exactly on the counter ceiling is a real measurement
    idle(254);
    sb.push_back(255);
    fin_edge();
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL max_ovf got=%0b expected=0", bus.ovf); end
    checks++;
    if (bus.period !== 8'd255) begin errors++; $display("FAIL max_period got=%0d expected=255", bus.period); end
  endtask

  task automatic test_clr();
    idle(3);
    sb.push_back(4);
    fin_edge();
    idle(3);
    sb.push_back(4);
    fin_edge();
    checks++;
    if (bus.lock !== 1'b1) begin errors++; $display("FAIL clr_prelock got=%0b expected=1", bus.lock); end
    idle(2);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    checks++;
    if (bus.lock !== 1'b0) begin errors++; $display("FAIL clr_lock got=%0b expected=0", bus.lock); end
    checks++;
    if (bus.period !== 8'd0) begin errors++; $display("FAIL clr_period got=%0d expected=0", bus.period); end
    idle(2);
    fin_edge();
    idle(4);
    sb.push_back(5);
    fin_edge();
    checks++;
    if (bus.period !== 8'd5) begin errors++; $display("FAIL clr_remeas got=%0d expected=5", bus.period); end
  endtask

  task automatic test_reset_mid();
    idle(4);
    sb.push_back(5);
    fin_edge();
    checks++;
    if (bus.lock !== 1'b1) begin errors++; $display("FAIL rmid_prelock got=%0b expected=1", bus.lock); end
    idle(2);
    bus.fin = 1'b1;
    rst_b = 1'b0;
    #1;
    checks++;
    if ({bus.lock, bus.ovf, bus.period_vld} !== 3'b000 || bus.period !== 8'd0) begin
      errors++;
      $display("FAIL rmid_outputs lock=%0b ovf=%0b vld=%0b period=%0d expected all 0",
               bus.lock, bus.ovf, bus.period_vld, bus.period);
    end
    tick();
    rst_b = 1'b1;
    idle(5);
    checks++;
    if (bus.lock !== 1'b0) begin errors++; $display("FAIL rmid_lock got=%0b expected=0", bus.lock); end
    bus.fin = 1'b0;
    idle(2);
    fin_edge();
    idle(3);
    sb.push_back(4);
    fin_edge();
    checks++;
    if (bus.period !== 8'd4) begin errors++; $display("FAIL rmid_remeas got=%0d expected=4", bus.period); end
  endtask

  initial begin
    rst_b = 1'b0;
    bus.clr = 1'b0;
    bus.en = 1'b1;
    bus.fin = 1'b1;
    test_reset();
    test_div4();
    test_change6();
    test_en_gap();
    test_ovf();
    test_clr();
    test_reset_mid();
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_missing_vld pending=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
